// File: rtl/fwd_pkg.sv
// Shared definitions for the BPFVM packet forwarder: default widths,
// FSM state encoding and the FIFO word layout.
package fwd_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned DEF_ADDR_WIDTH = 10;

   // Packet length counts words 0..2^ADDR_WIDTH, so it needs one extra bit.
   function automatic int unsigned plen_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE,
      ST_HOLD
   } fwd_state_t;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] data;
      logic                      last;
   } fwd_word_t;

endpackage

// File: rtl/fwd_fifo.sv
// First-word-fall-through FIFO with occupancy count. Writers must respect
// the count; a write into a full FIFO is not guarded.
module fwd_fifo #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [WIDTH-1:0]                 wr_data,
   input  logic                             rd_en,
   output logic [WIDTH-1:0]                 rd_data,
   output logic                             empty,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         case ({wr_en, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/packet_forwarder.sv
// Reads an offered packet word by word from the BPFVM forwarder port and
// streams it out over AXI-Stream, then pulses forwarder_done.
module packet_forwarder
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned PLEN_WIDTH = plen_width(ADDR_WIDTH),
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
   input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
   output logic                  forwarder_rd_en,
   output logic                  forwarder_done,
   input  logic                  ready_for_forwarder,
   input  logic [PLEN_WIDTH-1:0] len_to_forwarder,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
);

   localparam int unsigned DEPTH = RD_LATENCY + 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   fwd_state_t            state, state_nx;
   logic [PLEN_WIDTH-1:0] len_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0]         inflight_q;
   logic [CW-1:0]         fifo_count;
   logic [RD_LATENCY-1:0] vpipe;
   logic [RD_LATENCY-1:0] lpipe;
   logic [DATA_WIDTH:0]   fifo_out;
   logic                  fifo_empty;
   logic                  credit_ok;
   logic                  issue;
   logic                  is_last_rd;
   logic                  ret_valid;
   logic                  pop;
   logic                  last_hs;

   // Reads in flight reserve FIFO slots, so the FIFO can never overflow.
   assign credit_ok  = (32'(fifo_count) + 32'(inflight_q)) < DEPTH;
   assign issue      = (state == ST_READ) && credit_ok;
   assign is_last_rd = (PLEN_WIDTH'(addr_q) == len_q - PLEN_WIDTH'(1));
   assign ret_valid  = vpipe[RD_LATENCY-1];
   assign pop        = m_tvalid && m_tready;
   assign last_hs    = pop && fifo_out[0];

   assign forwarder_rd_en   = issue;
   assign forwarder_rd_addr = addr_q;
   assign forwarder_done    = (state == ST_DONE);
   assign m_tvalid          = !fifo_empty;
   assign m_tdata           = m_tvalid ? fifo_out[DATA_WIDTH:1] : '0;
   assign m_tlast           = m_tvalid && fifo_out[0];

   fwd_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ret_valid),
      .wr_data ({forwarder_rd_data, lpipe[RD_LATENCY-1]}),
      .rd_en   (pop),
      .rd_data (fifo_out),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; the zero-length test uses the live length because
   // len_q is only loaded on this same edge.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (ready_for_forwarder)
                      state_nx = (len_to_forwarder == '0) ? ST_DONE : ST_READ;
         ST_READ:  if (issue && is_last_rd) state_nx = ST_DRAIN;
         ST_DRAIN: if (inflight_q == '0 && fifo_count == CW'(1) && last_hs)
                      state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_HOLD;
         ST_HOLD:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Length latch and read address counter (wraps harmlessly at max length).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q  <= '0;
         addr_q <= '0;
      end else if (state == ST_IDLE && ready_for_forwarder) begin
         len_q  <= len_to_forwarder;
         addr_q <= '0;
      end else if (issue) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
      end
   end

   // Count of reads issued but not yet returned into the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
      end else begin
         case ({issue, ret_valid})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Valid/last delay line matching the read-data latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe <= '0;
         lpipe <= '0;
      end else begin
         vpipe[0] <= issue;
         lpipe[0] <= issue && is_last_rd;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
            lpipe[i] <= lpipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_packet_forwarder.sv
// Scoreboard bench: instance a (RD_LATENCY=1) and instance b (RD_LATENCY=3).
module tb_packet_forwarder;
   import fwd_pkg::*;

   localparam int DW = 64;
   localparam int AW = 10;
   localparam int PW = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] rdata_a, rdata_b;
   logic          en_a, en_b, done_a, done_b, rdy_a, rdy_b;
   logic [PW-1:0] len_a, len_b;
   logic [DW-1:0] tdata_a, tdata_b;
   logic          tvalid_a, tvalid_b, tready_a, tready_b, tlast_a, tlast_b;

   packet_forwarder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst),
      .forwarder_rd_addr(addr_a), .forwarder_rd_data(rdata_a), .forwarder_rd_en(en_a),
      .forwarder_done(done_a), .ready_for_forwarder(rdy_a), .len_to_forwarder(len_a),
      .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(tready_a), .m_tlast(tlast_a));

   packet_forwarder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst),
      .forwarder_rd_addr(addr_b), .forwarder_rd_data(rdata_b), .forwarder_rd_en(en_b),
      .forwarder_done(done_b), .ready_for_forwarder(rdy_b), .len_to_forwarder(len_b),
      .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(tready_b), .m_tlast(tlast_b));

   // Packet memory models: word at addr is base + addr, returned after the latency.
   logic [DW-1:0] base_a = '0, base_b = '0;
   logic [AW-1:0] pa;
   logic [AW-1:0] pb [3];
   always @(posedge clk) begin
      pa    <= addr_a;
      pb[0] <= addr_b;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign rdata_a = base_a + DW'(pa);
   assign rdata_b = base_b + DW'(pb[2]);

   fwd_word_t q_a[$];
   fwd_word_t q_b[$];
   int total = 0;
   int bad   = 0;

   int done_cnt_a = 0, done_cnt_b = 0;
   int tlast_cnt_b = 0;
   int issued_b = 0, accepted_b = 0, max_outst_b = 0;
   int seen_b [1024];
   bit track_b = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input bit sel, input logic [DW-1:0] base, input int n);
      fwd_word_t w;
      for (int i = 0; i < n; i++) begin
         w.data = base + DW'(i);
         w.last = (i == n - 1);
         if (sel) q_b.push_back(w);
         else     q_a.push_back(w);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit sel, input int target, input int budget, input string name);
      int c = 0;
      while ((sel ? done_cnt_b : done_cnt_a) < target && c < budget) begin
         tick();
         c++;
      end
      chk(name, 64'(sel ? done_cnt_b : done_cnt_a), 64'(target));
   endtask

   // Monitor a: pops the expected word on every stream handshake.
   always @(negedge clk) begin : mon_a
      fwd_word_t w;
      if (!rst) begin
         if (done_a) done_cnt_a++;
         if (tvalid_a && tready_a) begin
            if (q_a.size() == 0) begin
               chk("a_unexpected_beat", {tlast_a, tdata_a[62:0]}, 64'hDEAD);
            end else begin
               w = q_a.pop_front();
               chk("a_tdata", tdata_a, w.data);
               chk("a_tlast", 64'(tlast_a), 64'(w.last));
            end
         end
      end
   end

   // Monitor b: scoreboard plus read/outstanding bookkeeping.
   always @(negedge clk) begin : mon_b
      fwd_word_t w;
      if (!rst) begin
         if (done_b) done_cnt_b++;
         if (en_b) begin
            issued_b++;
            if (track_b) seen_b[addr_b]++;
         end
         if (tvalid_b && tready_b) begin
            accepted_b++;
            if (tlast_b) tlast_cnt_b++;
            if (q_b.size() == 0) begin
               chk("b_unexpected_beat", tdata_b, 64'hDEAD);
            end else begin
               w = q_b.pop_front();
               chk("b_tdata", tdata_b, w.data);
               chk("b_tlast", 64'(tlast_b), 64'(w.last));
            end
         end
         if (issued_b - accepted_b > max_outst_b) max_outst_b = issued_b - accepted_b;
      end
   end

   initial begin : watchdog
      #2000000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n, r0, a0, t0, miss;
      rst = 1'b1;
      rdy_a = 1'b0; rdy_b = 1'b0; len_a = '0; len_b = '0;
      tready_a = 1'b1; tready_b = 1'b1;
      repeat (3) tick();
      chk("rst_rd_en", 64'(en_a), 0);
      chk("rst_rd_addr", 64'(addr_a), 0);
      chk("rst_done", 64'(done_a), 0);
      chk("rst_tvalid", 64'(tvalid_a), 0);
      chk("rst_tlast", 64'(tlast_a), 0);
      chk("rst_tdata", tdata_a, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Len 4, latency 1: exact cycle timing.
      tick();
      base_a = 64'hA0; rdy_a = 1'b1; len_a = 11'd4;
      push_pkt(1'b0, 64'hA0, 4);
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 1) rdy_a = 1'b0;
         @(negedge clk);
         chk($sformatf("t1_rd_en_c%0d", k), 64'(en_a), 64'(k >= 1 && k <= 4));
         if (k <= 4) chk($sformatf("t1_addr_c%0d", k), 64'(addr_a), 64'(k - 1));
         chk($sformatf("t1_tvalid_c%0d", k), 64'(tvalid_a), 64'(k >= 3 && k <= 6));
         chk($sformatf("t1_done_c%0d", k), 64'(done_a), 64'(k == 7));
      end
      chk("t1_done_count", 64'(done_cnt_a), 1);

      // Empty packet: done only, no reads, no beats.
      tick();
      rdy_a = 1'b1; len_a = '0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) rdy_a = 1'b0;
         @(negedge clk);
         chk($sformatf("len0_rd_en_c%0d", k), 64'(en_a), 0);
         chk($sformatf("len0_tvalid_c%0d", k), 64'(tvalid_a), 0);
         chk($sformatf("len0_done_c%0d", k), 64'(done_a), 64'(k == 1));
      end
      chk("len0_done_count", 64'(done_cnt_a), 2);

      // Reset during READ of a len-8 packet after 3 reads.
      tready_a = 1'b0;
      tick();
      base_a = 64'hB0; rdy_a = 1'b1; len_a = 11'd8;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         tick();
         rdy_a = 1'b0;
         @(negedge clk);
         if (en_a) n++;
      end
      chk("rst_mid_reads", 64'(n), 3);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_rd_en", 64'(en_a), 0);
      chk("rst_mid_addr", 64'(addr_a), 0);
      chk("rst_mid_done", 64'(done_a), 0);
      chk("rst_mid_tvalid", 64'(tvalid_a), 0);
      chk("rst_mid_tlast", 64'(tlast_a), 0);
      chk("rst_mid_tdata", tdata_a, 0);
      tick();
      rst = 1'b0;
      tready_a = 1'b1;
      repeat (6) tick();
      chk("rst_mid_no_done", 64'(done_cnt_a), 2);
      tick();
      base_a = 64'hC0; rdy_a = 1'b1; len_a = 11'd2;
      push_pkt(1'b0, 64'hC0, 2);
      tick();
      rdy_a = 1'b0;
      wait_done(1'b0, 3, 40, "post_rst_done");

      // Latency 3, len 16, tready toggling every cycle.
      t0 = tlast_cnt_b;
      tick();
      base_b = 64'h1000; rdy_b = 1'b1; len_b = 11'd16;
      push_pkt(1'b1, 64'h1000, 16);
      tick();
      rdy_b = 1'b0;
      for (int c = 0; c < 300 && done_cnt_b < 1; c++) begin
         tick();
         tready_b = ~tready_b;
      end
      tready_b = 1'b1;
      chk("tog_done", 64'(done_cnt_b), 1);
      chk("tog_tlast_once", 64'(tlast_cnt_b - t0), 1);
      chk("tog_outstanding_le5", 64'(max_outst_b > 5 ? max_outst_b : 5), 5);

      // Long backpressure mid-packet.
      tick();
      base_b = 64'h2000; rdy_b = 1'b1; len_b = 11'd20;
      push_pkt(1'b1, 64'h2000, 20);
      a0 = accepted_b;
      tick();
      rdy_b = 1'b0;
      for (int c = 0; c < 50 && accepted_b - a0 < 6; c++) tick();
      chk("stall_start", 64'(accepted_b - a0 >= 6), 1);
      tready_b = 1'b0;
      r0 = issued_b;
      repeat (50) tick();
      @(negedge clk);
      chk("stall_rd_en_stopped", 64'(en_b), 0);
      chk("stall_reads_le_depth", 64'(issued_b - r0 > 5 ? issued_b - r0 : 5), 5);
      chk("stall_no_beats", 64'(accepted_b - a0), 6);
      tick();
      tready_b = 1'b1;
      wait_done(1'b1, 2, 100, "stall_done");
      chk("stall_outstanding_le5", 64'(max_outst_b > 5 ? max_outst_b : 5), 5);

      // Maximum length 1024.
      t0 = tlast_cnt_b;
      track_b = 1'b1;
      tick();
      base_b = 64'hFACE_0000_0000_0000; rdy_b = 1'b1; len_b = 11'd1024;
      push_pkt(1'b1, 64'hFACE_0000_0000_0000, 1024);
      tick();
      rdy_b = 1'b0;
      wait_done(1'b1, 3, 1300, "max_done");
      track_b = 1'b0;
      miss = 0;
      for (int i = 0; i < 1024; i++) if (seen_b[i] != 1) miss++;
      chk("max_addr_once_each", 64'(miss), 0);
      chk("max_tlast_once", 64'(tlast_cnt_b - t0), 1);
      repeat (6) tick();
      chk("max_done_once", 64'(done_cnt_b), 3);

      chk("a_queue_empty", 64'(q_a.size()), 0);
      chk("b_queue_empty", 64'(q_b.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
